main_1: RTL and testbench
=========================

Name: main_1

Overview:
- Top-level closed-loop BLDC motor controller.
- Measures rotor speed from an encoder tick input and runs a PI loop (fixed Kp, runtime Ki) toward a target speed, producing an 8-bit PWM duty.
- Drives six-step, Hall-sensor-based commutation of a three-phase bridge: high-side gates PWM-chopped, low-side gates held on, dead time inserted at every sector change.

Parameters:
- VEL_WINDOW, 12500000, clock cycles per speed-measurement window (250 ms at 50 MHz).
- KP, 4, proportional gain (unsigned integer multiplier).
- ACC_SHIFT, 4, arithmetic right shift applied to the integrator before summing.
- PWM_DIV, 8, clock cycles per PWM counter step (24.4 kHz PWM at 50 MHz).
- DEADTIME, 4, clock cycles with all gates off after a sector change.

Ports:
- CLK, in, 1, system clock (50 MHz nominal).
- RST, in, 1, synchronous active-high reset.
- H1, in, 1, Hall sensor 1 (asynchronous).
- H2, in, 1, Hall sensor 2 (asynchronous).
- H3, in, 1, Hall sensor 3 (asynchronous).
- ticks_encoder, in, 1, encoder pulse; asynchronous; one count per rising edge.
- target_vel, in, 10, target speed in encoder rising edges per window (unsigned).
- Ki, in, 4, integral gain (unsigned).
- A, out, 1, phase A high-side gate.
- AA, out, 1, phase A low-side gate.
- B, out, 1, phase B high-side gate.
- BB, out, 1, phase B low-side gate.
- C, out, 1, phase C high-side gate.
- CC, out, 1, phase C low-side gate.

Behaviour:
- Reset (RST=1 at a CLK edge) clears every register. All six outputs are 0; duty, integrator, window counter, edge counter, measured speed and PWM counters are 0; dead-time counter is loaded with DEADTIME.
- Input synchronisation: H1..H3 and ticks_encoder each pass through 2-FF synchronisers.
- Hall code: hall = {H1,H2,H3} after synchronisation.
- Speed measurement:
  - A rising edge of synced ticks_encoder increments a 10-bit edge counter, saturating at 1023.
  - The window counter counts 0..VEL_WINDOW-1. On its terminal cycle, meas_vel <= edge count and the edge counter clears.
  - An edge arriving in the terminal cycle is counted into the closing window.
- PI update, once per window, the cycle after meas_vel loads:
  - err = target_vel - meas_vel, signed 11-bit.
  - acc <= sat16(acc + Ki*err), signed 16-bit, saturating at -32768/+32767 (anti-windup).
  - u = KP*err + (acc >>> ACC_SHIFT), using the new acc value.
  - duty <= clamp(u, 0, 255).
- PWM:
  - An 8-bit pwm_cnt advances once per PWM_DIV clocks and wraps 255 -> 0.
  - pwm_on = (pwm_cnt < duty). duty=0 means never on; duty=255 means on 255/256 of the period.
  - A new duty is applied only at pwm_cnt wrap, so no glitches occur.
- Commutation, as hall -> (high-side PWM, low-side on):
  - 100 -> A, BB
  - 101 -> A, CC
  - 001 -> B, CC
  - 011 -> B, AA
  - 010 -> C, AA
  - 110 -> C, BB
  - 000 and 111 are faults: all six outputs 0.
  - The selected high-side output = pwm_on; the selected low-side output = 1; all others 0.
- Dead time: when the synced hall code changes, all outputs are 0 for DEADTIME cycles, then the new sector drives.
- Safety invariant: X and XX are never 1 simultaneously, for any phase and any input.
- Outputs are registered.
- Latency: 3 CLK from a Hall change to outputs forced off (2 sync + 1 output register).
- Reset asserted mid-operation takes effect at the next edge, with no partial state retained.

Test Plan:
- Reset: hold RST=1 with hall=100 -> A=AA=B=BB=C=CC=0 throughout; after release, BB=1 following DEADTIME+3 cycles; A=0 (duty 0).
- Six-step rotation: halls cycle 100,101,001,011,010,110 with 1000 ns per step (sequence from H1: 1 for 2000/0 for 3000/1 for 1000; H2: 0 for 3000/1 for 3000; H3: 0 for 1000/1 for 3000/0 for 2000) -> low-side sequence BB,CC,CC,AA,AA,BB; each transition shows ≥DEADTIME all-zero cycles; no X/XX overlap.
- No encoder, Ki=0, target_vel=40: after first window meas_vel=0, err=40, duty=160 -> active high-side high 160 of 256 PWM steps.
- Encoder toggling every 3906250 ns (32 rising edges/window), Ki=0, target_vel=40 -> meas_vel=32, err=8, duty=32.
- Ki=4, target_vel=40, no encoder -> window 1: acc=160, duty=170; duty rises monotonically and saturates at 255; acc saturates at 32767 without wrap.
- Fault codes 000 and 111 -> all outputs 0 while held; on return to a valid code, dead time applies, then normal drive.

Source files
------------

// File: rtl/main_1.sv
// ---------------------------------------------------------------------------
// main_1 : closed-loop six-step BLDC motor controller.
//
// Measures rotor speed by counting encoder rising edges per fixed window,
// runs a PI loop toward a target speed, turns the result into an 8-bit PWM
// duty, and drives Hall-sensor commutation of a three-phase bridge.
// In the active sector, the high-side gate is PWM-chopped and the low-side
// gate is held on. Every sector change forces all gates off for a dead time.
//
// Parameters:
//   VEL_WINDOW : clock cycles per speed-measurement window
//   KP         : proportional gain (unsigned integer multiplier)
//   ACC_SHIFT  : arithmetic right shift applied to the integrator
//   PWM_DIV    : clock cycles per PWM counter step
//   DEADTIME   : all-gates-off cycles after a sector change (>= 1)
//
// Ports:
//   CLK           in   system clock
//   RST           in   synchronous active-high reset
//   H1, H2, H3    in   Hall sensors (asynchronous)
//   ticks_encoder in   encoder pulse (asynchronous), one count per rising edge
//   target_vel    in   [9:0] target speed in encoder edges per window
//   Ki            in   [3:0] integral gain (unsigned)
//   A/AA, B/BB,
//   C/CC          out  high-side / low-side gates of phases A, B, C
// ---------------------------------------------------------------------------
module main_1 #(
    parameter int VEL_WINDOW = 12500000,
    parameter int KP         = 4,
    parameter int ACC_SHIFT  = 4,
    parameter int PWM_DIV    = 8,
    parameter int DEADTIME   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       H1,
    input  logic       H2,
    input  logic       H3,
    input  logic       ticks_encoder,
    input  logic [9:0] target_vel,
    input  logic [3:0] Ki,
    output logic       A,
    output logic       AA,
    output logic       B,
    output logic       BB,
    output logic       C,
    output logic       CC
);

    localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int DT_W  = $clog2(DEADTIME + 1);
    localparam logic signed [17:0] KP_S = 18'(KP);

    // Registered state
    logic [2:0]        hall_s1_q, hall_s1_d;
    logic [2:0]        hall_s2_q, hall_s2_d;
    logic [2:0]        hall_last_q, hall_last_d;
    logic              enc_s1_q, enc_s1_d;
    logic              enc_s2_q, enc_s2_d;
    logic              enc_prev_q, enc_prev_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [9:0]        edge_cnt_q, edge_cnt_d;
    logic [9:0]        meas_vel_q, meas_vel_d;
    logic              pi_go_q, pi_go_d;
    logic signed [15:0] acc_q, acc_d;
    logic [7:0]        duty_q, duty_d;
    logic [7:0]        duty_act_q, duty_act_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [DT_W-1:0]   dt_cnt_q, dt_cnt_d;
    logic [5:0]        gates_q, gates_d;

    // Combinational intermediates
    logic               enc_rise;
    logic               win_last;
    logic [9:0]         edge_cnt_inc;
    logic signed [10:0] err;
    logic signed [17:0] err_ext;
    logic signed [17:0] ki_ext;
    logic signed [17:0] ki_term;
    logic signed [17:0] acc_sum;
    logic signed [15:0] acc_new;
    logic signed [17:0] acc_new_ext;
    logic signed [17:0] p_term;
    logic signed [17:0] i_term;
    logic signed [17:0] u;
    logic [7:0]         duty_new;
    logic               div_last;
    logic               pwm_on;
    logic               hall_chg;
    logic [5:0]         drive;

    // Synchronisers, speed measurement and window timing.
    // An edge seen on the terminal cycle is folded into the closing window.
    always_comb begin
        hall_s1_d  = {H1, H2, H3};
        hall_s2_d  = hall_s1_q;
        enc_s1_d   = ticks_encoder;
        enc_s2_d   = enc_s1_q;
        enc_prev_d = enc_s2_q;

        enc_rise = enc_s2_q & ~enc_prev_q;
        win_last = (win_cnt_q == WIN_W'(VEL_WINDOW - 1));

        if (enc_rise && (edge_cnt_q != 10'h3FF)) begin
            edge_cnt_inc = edge_cnt_q + 10'd1;
        end else begin
            edge_cnt_inc = edge_cnt_q;
        end

        meas_vel_d = meas_vel_q;
        if (win_last) begin
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            meas_vel_d = edge_cnt_inc;
        end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            edge_cnt_d = edge_cnt_inc;
        end
        pi_go_d = win_last;
    end

    // PI controller. Runs the cycle after meas_vel loads. The integrator
    // saturates instead of wrapping so a long stall cannot flip its sign,
    // and the proportional sum uses the freshly updated integrator.
    always_comb begin
        err     = $signed({1'b0, target_vel}) - $signed({1'b0, meas_vel_q});
        err_ext = {{7{err[10]}}, err};
        ki_ext  = $signed({14'd0, Ki});
        ki_term = ki_ext * err_ext;
        acc_sum = $signed({{2{acc_q[15]}}, acc_q}) + ki_term;

        if (acc_sum > 18'sd32767) begin
            acc_new = 16'sh7FFF;
        end else if (acc_sum < -18'sd32768) begin
            acc_new = 16'sh8000;
        end else begin
            acc_new = acc_sum[15:0];
        end

        acc_new_ext = {{2{acc_new[15]}}, acc_new};
        i_term      = acc_new_ext >>> ACC_SHIFT;
        p_term      = err_ext * KP_S;
        u           = p_term + i_term;

        if (u < 18'sd0) begin
            duty_new = 8'd0;
        end else if (u > 18'sd255) begin
            duty_new = 8'd255;
        end else begin
            duty_new = u[7:0];
        end

        acc_d  = acc_q;
        duty_d = duty_q;
        if (pi_go_q) begin
            acc_d  = acc_new;
            duty_d = duty_new;
        end
    end

    // PWM timebase. The active duty is only refreshed as the counter wraps
    // to zero, so a PI update can never shorten or stretch a running pulse.
    always_comb begin
        div_last   = (div_cnt_q == DIV_W'(PWM_DIV - 1));
        pwm_cnt_d  = pwm_cnt_q;
        duty_act_d = duty_act_q;
        if (div_last) begin
            div_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                duty_act_d = duty_q;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        pwm_on = (pwm_cnt_q < duty_act_q);
    end

    // Commutation table, gate order {A, AA, B, BB, C, CC}. Each entry selects
    // at most one gate per phase, which keeps high and low side exclusive.
    always_comb begin
        case (hall_s2_q)
            3'b100:  drive = {pwm_on, 1'b0,   1'b0,   1'b1, 1'b0,   1'b0};
            3'b101:  drive = {pwm_on, 1'b0,   1'b0,   1'b0, 1'b0,   1'b1};
            3'b001:  drive = {1'b0,   1'b0,   pwm_on, 1'b0, 1'b0,   1'b1};
            3'b011:  drive = {1'b0,   1'b1,   pwm_on, 1'b0, 1'b0,   1'b0};
            3'b010:  drive = {1'b0,   1'b1,   1'b0,   1'b0, pwm_on, 1'b0};
            3'b110:  drive = {1'b0,   1'b0,   1'b0,   1'b1, pwm_on, 1'b0};
            default: drive = 6'b000000;
        endcase
    end

    // Dead-time sequencing. The change cycle itself already produces an
    // off cycle, so the counter is loaded with DEADTIME-1 to give exactly
    // DEADTIME all-off output cycles before the new sector drives.
    always_comb begin
        hall_chg    = (hall_s2_q != hall_last_q);
        hall_last_d = hall_s2_q;
        dt_cnt_d    = dt_cnt_q;
        gates_d     = drive;
        if (hall_chg) begin
            dt_cnt_d = DT_W'(DEADTIME - 1);
            gates_d  = 6'b000000;
        end else if (dt_cnt_q != '0) begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
            gates_d  = 6'b000000;
        end
    end

    // State register. Reset clears everything and arms the dead time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hall_s1_q   <= '0;
            hall_s2_q   <= '0;
            hall_last_q <= '0;
            enc_s1_q    <= 1'b0;
            enc_s2_q    <= 1'b0;
            enc_prev_q  <= 1'b0;
            win_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            meas_vel_q  <= '0;
            pi_go_q     <= 1'b0;
            acc_q       <= '0;
            duty_q      <= '0;
            duty_act_q  <= '0;
            div_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            dt_cnt_q    <= DT_W'(DEADTIME);
            gates_q     <= '0;
        end else begin
            hall_s1_q   <= hall_s1_d;
            hall_s2_q   <= hall_s2_d;
            hall_last_q <= hall_last_d;
            enc_s1_q    <= enc_s1_d;
            enc_s2_q    <= enc_s2_d;
            enc_prev_q  <= enc_prev_d;
            win_cnt_q   <= win_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            meas_vel_q  <= meas_vel_d;
            pi_go_q     <= pi_go_d;
            acc_q       <= acc_d;
            duty_q      <= duty_d;
            duty_act_q  <= duty_act_d;
            div_cnt_q   <= div_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            dt_cnt_q    <= dt_cnt_d;
            gates_q     <= gates_d;
        end
    end

    assign {A, AA, B, BB, C, CC} = gates_q;

endmodule

// File: tb/tb_main_1.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// tb_main_1 : directed testbench for main_1.
// Uses a 2000-cycle speed window and an undivided PWM clock so several
// PI updates fit in a short run; the control law itself is unchanged.
// ---------------------------------------------------------------------------
module tb_main_1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       H1 = 1'b1;
    logic       H2 = 1'b0;
    logic       H3 = 1'b0;
    logic       ticks_encoder = 1'b0;
    logic [9:0] target_vel = 10'd0;
    logic [3:0] Ki = 4'd0;
    logic       A, AA, B, BB, C, CC;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;
    bit  enc_en = 1'b0;
    int  on_count;

    // Hall sequence after 100 and the gate pattern each sector should show
    // with zero duty, ordered {A, AA, B, BB, C, CC}.
    logic [2:0] hall_seq [5] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110};
    logic [5:0] low_seq  [5] = '{6'b000001, 6'b000001, 6'b010000,
                                 6'b010000, 6'b000100};

    main_1 #(
        .VEL_WINDOW(2000),
        .KP(4),
        .ACC_SHIFT(4),
        .PWM_DIV(1),
        .DEADTIME(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .H1(H1),
        .H2(H2),
        .H3(H3),
        .ticks_encoder(ticks_encoder),
        .target_vel(target_vel),
        .Ki(Ki),
        .A(A),
        .AA(AA),
        .B(B),
        .BB(BB),
        .C(C),
        .CC(CC)
    );

    // 100 MHz bench clock
    always #5 CLK = ~CLK;

    // Encoder with a 625 ns period: exactly 32 rising edges per 20 us window
    initial begin
        forever begin
            #312.5;
            if (enc_en) ticks_encoder = ~ticks_encoder;
            else        ticks_encoder = 1'b0;
        end
    end

    function automatic int gatesNow();
        return int'({A, AA, B, BB, C, CC});
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] hall, input logic [9:0] tgt,
                                 input logic [3:0] ki);
        @(negedge CLK);
        {H1, H2, H3} = hall;
        target_vel   = tgt;
        Ki           = ki;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic holdReset(input int n);
        @(negedge CLK);
        RST = 1'b1;
        repeat (n) begin
            waitEdges(1);
            checkOutput("reset_hold", gatesNow(), 0);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic countOn(output int cnt);
        cnt = 0;
        repeat (256) begin
            waitEdges(1);
            if (A) cnt++;
        end
    endtask

    // High and low side of one phase must never be on together
    always @(negedge CLK) begin
        if (mon_en) begin
            checkOutput("overlap", int'((A & AA) | (B & BB) | (C & CC)), 0);
        end
    end

    initial begin
        $display("[TB] start");

        // Reset with hall 100, then DEADTIME+3 cycles before BB comes on
        holdReset(3);
        mon_en = 1'b1;
        waitEdges(6);
        checkOutput("post_reset_dead", gatesNow(), 0);
        waitEdges(1);
        checkOutput("post_reset_BB", gatesNow(), 'h04);

        // Six-step rotation with zero duty: dead time then new low side
        for (int i = 0; i < 5; i++) begin
            applyStimulus(hall_seq[i], 10'd0, 4'd0);
            waitEdges(3);
            checkOutput("step_dt_start", gatesNow(), 0);
            waitEdges(3);
            checkOutput("step_dt_end", gatesNow(), 0);
            waitEdges(1);
            checkOutput("step_drive", gatesNow(), int'(low_seq[i]));
            waitEdges(90);
            checkOutput("step_steady", gatesNow(), int'(low_seq[i]));
        end

        // No encoder, Ki=0, target 40: duty = 4*40 = 160
        applyStimulus(3'b100, 10'd40, 4'd0);
        holdReset(2);
        waitEdges(2300);
        countOn(on_count);
        checkOutput("duty_ki0", on_count, 160);

        // 32 edges per window, Ki=0, target 40: duty = 4*8 = 32
        enc_en = 1'b1;
        applyStimulus(3'b100, 10'd40, 4'd0);
        holdReset(2);
        waitEdges(6300);
        countOn(on_count);
        checkOutput("duty_enc", on_count, 32);

        // Speed above target: u = 4*(-32) = -128, clamps to 0
        applyStimulus(3'b100, 10'd0, 4'd0);
        waitEdges(1800);
        countOn(on_count);
        checkOutput("duty_neg_clamp", on_count, 0);
        enc_en = 1'b0;

        // Ki=4: acc 160 -> duty 170, then acc 320 -> duty 180
        applyStimulus(3'b100, 10'd40, 4'd4);
        holdReset(2);
        waitEdges(2300);
        countOn(on_count);
        checkOutput("ki4_window1", on_count, 170);
        waitEdges(1744);
        countOn(on_count);
        checkOutput("ki4_window2", on_count, 180);

        // Integrator saturation: 15345, 30690, then clipped at 32767
        applyStimulus(3'b100, 10'd1023, 4'd15);
        holdReset(2);
        waitEdges(6300);
        countOn(on_count);
        checkOutput("sat_high", on_count, 255);
        // With zero error the duty comes only from acc: 32767>>>4 -> 255.
        // A wrapped integrator would have gone negative and given 0.
        applyStimulus(3'b100, 10'd0, 4'd0);
        waitEdges(1700);
        countOn(on_count);
        checkOutput("acc_no_wrap", on_count, 255);

        // Fault codes force all gates off, return pays the dead time
        applyStimulus(3'b000, 10'd0, 4'd0);
        waitEdges(3);
        checkOutput("fault000_enter", gatesNow(), 0);
        waitEdges(20);
        checkOutput("fault000_hold", gatesNow(), 0);
        applyStimulus(3'b111, 10'd0, 4'd0);
        waitEdges(3);
        checkOutput("fault111_enter", gatesNow(), 0);
        waitEdges(20);
        checkOutput("fault111_hold", gatesNow(), 0);
        applyStimulus(3'b100, 10'd0, 4'd0);
        waitEdges(3);
        checkOutput("fault_ret_dt_start", gatesNow(), 0);
        waitEdges(3);
        checkOutput("fault_ret_dt_end", gatesNow(), 0);
        waitEdges(1);
        checkOutput("fault_ret_drive", gatesNow() & 'h1F, 'h04);

        // Reset mid-run clears gates at the next edge and drops the duty
        @(negedge CLK);
        RST = 1'b1;
        waitEdges(1);
        checkOutput("mid_reset", gatesNow(), 0);
        @(negedge CLK);
        RST = 1'b0;
        waitEdges(7);
        checkOutput("mid_reset_recover", gatesNow(), 'h04);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
